// File: rtl/xnor3_seq_pkg.sv
// Shared types and constants for the three-operand sequential XNOR block.
// Optional parity output is controlled by XNOR3_SEQ_PARITY_EN in the top module.
package xnor3_seq_pkg;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      SR = 2'd3
   } state_e;

   localparam int unsigned GrpCntW = 16;

endpackage

// File: rtl/xnor3_seq_dp.sv
// Purely combinational bitwise three-input XNOR datapath.
module xnor3_seq_dp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] c_i,
   output logic [WIDTH-1:0] zn_o
);

   assign zn_o = ~(a_i ^ b_i ^ c_i);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_seq.sv
// Collects three operand words by handshake and registers ZN = ~(A1^A2^A3) with a group count.
// Defining XNOR3_SEQ_PARITY_EN adds OUT_PAR, the registered XOR-reduction of ZN.
module gf180mcu_fd_sc_mcu7t5v0__xnor3_seq
   import xnor3_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CLR,
   input  logic [WIDTH-1:0]   IN_DATA,
   input  logic               IN_VALID,
   output logic               IN_READY,
   output logic [WIDTH-1:0]   ZN,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
`ifdef XNOR3_SEQ_PARITY_EN
   output logic               OUT_PAR,
`endif
   output logic [GrpCntW-1:0] GRP_CNT
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a1_q, a1_d;
   logic [WIDTH-1:0]     a2_q, a2_d;
   logic [WIDTH-1:0]     zn_q, zn_d;
   logic [GrpCntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     dp_zn;
   logic                 in_hs;
   logic                 out_hs;
`ifdef XNOR3_SEQ_PARITY_EN
   logic                 par_q, par_d;
`endif

   xnor3_seq_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .a_i  (a1_q),
      .b_i  (a2_q),
      .c_i  (IN_DATA),
      .zn_o (dp_zn)
   );

   // Ready only stalls while a result is held; reset forces it high.
   assign IN_READY  = RST || (state_q != SR) || OUT_READY;
   assign OUT_VALID = (state_q == SR);
   assign in_hs     = IN_VALID && IN_READY;
   assign out_hs    = OUT_VALID && OUT_READY;
   assign ZN        = zn_q;
   assign GRP_CNT   = cnt_q;
`ifdef XNOR3_SEQ_PARITY_EN
   assign OUT_PAR   = par_q;
`endif

   always_comb begin
      state_d = state_q;
      a1_d    = a1_q;
      a2_d    = a2_q;
      zn_d    = zn_q;
      cnt_d   = cnt_q + GrpCntW'(out_hs);
`ifdef XNOR3_SEQ_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S0: begin
            if (in_hs) begin
               a1_d    = IN_DATA;
               state_d = S1;
            end
         end
         S1: begin
            if (CLR) begin
               state_d = S0;
            end else if (in_hs) begin
               a2_d    = IN_DATA;
               state_d = S2;
            end
         end
         S2: begin
            if (CLR) begin
               state_d = S0;
            end else if (in_hs) begin
               zn_d    = dp_zn;
`ifdef XNOR3_SEQ_PARITY_EN
               par_d   = ^dp_zn;
`endif
               state_d = SR;
            end
         end
         SR: begin
            // A word accepted while the result leaves starts the next group.
            if (out_hs) begin
               if (in_hs) begin
                  a1_d    = IN_DATA;
                  state_d = S1;
               end else begin
                  state_d = S0;
               end
            end
         end
         default: state_d = S0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S0;
         a1_q    <= '0;
         a2_q    <= '0;
         zn_q    <= '0;
         cnt_q   <= '0;
`ifdef XNOR3_SEQ_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         zn_q    <= zn_d;
         cnt_q   <= cnt_d;
`ifdef XNOR3_SEQ_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor3_seq.sv
// Scoreboard bench: expected results are queued at issue, a forked monitor checks each delivery.
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor3_seq;
   import xnor3_seq_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CLR;
   logic [7:0]  IN_DATA;
   logic        IN_VALID;
   logic        IN_READY;
   logic [7:0]  ZN;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] GRP_CNT;
`ifdef XNOR3_SEQ_PARITY_EN
   logic        OUT_PAR;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_q[$];

   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu7t5v0__xnor3_seq #(
      .WIDTH (8)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CLR       (CLR),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .ZN        (ZN),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
`ifdef XNOR3_SEQ_PARITY_EN
      .OUT_PAR   (OUT_PAR),
`endif
      .GRP_CNT   (GRP_CNT)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one word; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [7:0] w);
      bit ok = 1'b0;
      IN_DATA  = w;
      IN_VALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (IN_READY) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge CLK);
         #1;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; CLR = 1'b0; IN_DATA = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;

      fork
         forever begin
            logic [7:0] e;
            @(negedge CLK);
            if (!RST && OUT_VALID && OUT_READY) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_result", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("zn", ZN, e);
`ifdef XNOR3_SEQ_PARITY_EN
                  chk("out_par", OUT_PAR, ^e);
`endif
               end
            end
         end
      join_none

      // Reset values, IN_READY high while in reset
      step(); step();
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_zn", ZN, 0);
      chk("rst_grp_cnt", GRP_CNT, 0);
      RST = 1'b0;
      step();

      // 0F,33,55 back-to-back -> ~(0x69) = 0x96
      OUT_READY = 1'b1;
      exp_q.push_back(8'h96);
      send(8'h0F); send(8'h33); send(8'h55);
      chk("t1_valid_lat1", OUT_VALID, 1);
      chk("t1_zn", ZN, 8'h96);
      step();
      chk("t1_valid_drop", OUT_VALID, 0);
      chk("t1_grp_cnt", GRP_CNT, 1);

      // Stalled result: ~(FF^00^AA) = ~0x55 = 0xAA held for 5 cycles
      OUT_READY = 1'b0;
      exp_q.push_back(8'hAA);
      send(8'hFF); send(8'h00); send(8'hAA);
      IN_DATA  = 8'h12;
      IN_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("t2_zn_hold", ZN, 8'hAA);
         chk("t2_valid_hold", OUT_VALID, 1);
         chk("t2_in_ready", IN_READY, 0);
      end
      step();
      // Simultaneous output and input handshake in SR
      OUT_READY = 1'b1;
      step();
      IN_VALID = 1'b0;
      chk("t3_valid_fall", OUT_VALID, 0);
      chk("t3_state_s1", dut.state_q, S1);
      chk("t3_grp_cnt", GRP_CNT, 2);
      exp_q.push_back(8'h8F);
      send(8'h34); send(8'h56);
      drain();
      chk("t3_grp_cnt2", GRP_CNT, 3);

      // CLR in S2 drops the group and ignores the concurrent word
      OUT_READY = 1'b0;
      send(8'h01); send(8'h02);
      CLR = 1'b1; IN_DATA = 8'h99; IN_VALID = 1'b1;
      step();
      CLR = 1'b0; IN_VALID = 1'b0;
      chk("t4_state_s0", dut.state_q, S0);
      chk("t4_valid", OUT_VALID, 0);
      exp_q.push_back(8'hFF);
      send(8'h00); send(8'h00); send(8'h00);
      // CLR while a result is held must not drop it
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      chk("t4_sr_clr_valid", OUT_VALID, 1);
      chk("t4_sr_clr_zn", ZN, 8'hFF);
      OUT_READY = 1'b1;
      drain();
      chk("t4_grp_cnt", GRP_CNT, 4);

      // Reset in S2
      send(8'hAB); send(8'hCD);
      RST = 1'b1; IN_DATA = 8'hEF; IN_VALID = 1'b1;
      step();
      RST = 1'b0; IN_VALID = 1'b0;
      chk("t5_s2_state", dut.state_q, S0);
      chk("t5_s2_valid", OUT_VALID, 0);
      chk("t5_s2_zn", ZN, 0);
      chk("t5_s2_grp_cnt", GRP_CNT, 0);
      step();
      chk("t5_s2_no_spurious", OUT_VALID, 0);

      // Reset in SR: result never delivered
      OUT_READY = 1'b0;
      send(8'h11); send(8'h22); send(8'h33);
      chk("t5_sr_valid_pre", OUT_VALID, 1);
      RST = 1'b1;
      #1;
      chk("t5_sr_rst_in_ready", IN_READY, 1);
      OUT_READY = 1'b1;
      step();
      RST = 1'b0;
      chk("t5_sr_state", dut.state_q, S0);
      chk("t5_sr_valid", OUT_VALID, 0);
      chk("t5_sr_zn", ZN, 0);
      chk("t5_sr_grp_cnt", GRP_CNT, 0);

      // Counter wrap from 0xFFFF
      force dut.cnt_q = 16'hFFFF;
      #1;
      release dut.cnt_q;
      step();
      chk("t6_preload", GRP_CNT, 16'hFFFF);
      exp_q.push_back(8'hF8);
      send(8'h01); send(8'h02); send(8'h04);
      drain();
      chk("t6_wrap", GRP_CNT, 16'h0000);

      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
